// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store controller.
package lsu_pkg;

  // RV32I load/store width and sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Controller state encoding
  typedef logic [2:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE   = 3'd0;
  localparam lsu_state_t ST_LOAD   = 3'd1;
  localparam lsu_state_t ST_RMW_RD = 3'd2;
  localparam lsu_state_t ST_WRITE  = 3'd3;
  localparam lsu_state_t ST_RESP   = 3'd4;

  // A request is legal when its width code exists for its direction and the
  // byte offset is naturally aligned for that width.
  function automatic logic is_legal(input logic       we,
                                    input logic [2:0] funct3,
                                    input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data, and merges sub-word store data into a word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  // Select the addressed byte and halfword lanes (little-endian)
  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  // Sign- or zero-extend the selected lane according to the width code
  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  // Replace only the targeted lane(s) of the previously read word
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_lane = i_wdata;
    case (i_funct3)
      F3_B: begin
        w_mask = 32'h0000_00FF << {i_off, 3'b000};
        w_lane = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        w_mask = 32'h0000_FFFF << {i_off[1], 4'b0000};
        w_lane = {2{i_wdata[15:0]}};
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_lane = i_wdata;
      end
    endcase
    o_store = (i_old & ~w_mask) | (w_lane & w_mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns RV32I byte/half/word accesses into word accesses on the data memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_write_data,
  output logic              dm_mem_write,
  input  logic [DATA_W-1:0] dm_read_data
);

  lsu_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_f3;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_store;

  lsu_align u_align (
    .i_word   (dm_read_data),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_old    (r_old),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  // Request sequencing, operand latching, RMW capture and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= 3'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_old   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_f3    <= funct3;
            r_we    <= mem_we;
            if (!is_legal(mem_we, funct3, addr[1:0])) begin
              r_err   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_err <= 1'b0;
              if (!mem_we)             r_state <= ST_LOAD;
              else if (funct3 == F3_W) r_state <= ST_WRITE;
              else                     r_state <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          r_rdata <= w_load;
          r_state <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_old   <= dm_read_data;
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Status and memory-side outputs decoded from the current state
  always_comb begin
    busy          = (r_state != ST_IDLE);
    done          = (r_state == ST_RESP);
    err           = done & r_err;
    rdata         = r_rdata;
    dm_address    = busy ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    dm_write_data = (r_state == ST_WRITE) ? w_store : '0;
    // WRITE is only reachable for stores; reset gates an in-flight write immediately
    dm_mem_write  = (r_state == ST_WRITE) && r_we && !rst;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, reset/busy corner sequences, random vs model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic        dm_mem_write;
  logic [31:0] dm_read_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .done          (done),
    .err           (err),
    .busy          (busy),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_mem_write  (dm_mem_write),
    .dm_read_data  (dm_read_data)
  );

  // Bench data memory, 256 words, with a back-door preload port
  logic [31:0] mem [256];
  logic        init_we = 1'b0;
  logic [7:0]  init_idx = 8'd0;
  logic [31:0] init_data = 32'd0;
  logic [31:0] ref_mem [256];

  assign dm_read_data = mem[dm_address[9:2]];

  always @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_data;
    else if (dm_mem_write) mem[dm_address[9:2]] <= dm_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    init_we = 1'b1; init_idx = idx; init_data = val;
    @(posedge clk); #1;
    init_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and follow it to the done pulse, then back to IDLE
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic e, output int wr);
    mem_we = we; funct3 = f3; addr = a; wdata = wd; mem_req = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); mem_we = 1'($urandom);
    lat = -1; e = 1'b0; wr = 0;
    for (int c = 1; c <= 8; c++) begin
      if (dm_mem_write) wr++;
      if (done) begin
        lat = c; e = err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model, written from the access rules rather than the RTL structure
  function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic ok;
    if (!we) ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else     ok = (f3 <= 2);
    sz = (f3 == 2) ? 4 : ((f3 == 1) || (f3 == 5)) ? 2 : 1;
    return ok && ((a % sz) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] b, h;
    int sh;
    sh = 8 * (a % 4);
    b = (w >> sh) & 32'hFF;
    h = (w >> sh) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] mask, val;
    int sh;
    sh = 8 * (a % 4);
    if (f3 == 0)      begin mask = 32'hFF << sh;   val = (wd & 32'hFF) << sh;   end
    else if (f3 == 1) begin mask = 32'hFFFF << sh; val = (wd & 32'hFFFF) << sh; end
    else              begin mask = 32'hFFFF_FFFF;  val = wd;                    end
    return (old & ~mask) | val;
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          writes;
    logic [7:0]  widx;
    logic [31:0] word;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input logic e,
                              input logic [31:0] rd, input int writes, input logic [7:0] widx,
                              input logic [31:0] word);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.lat = lat; v.e = e; v.rd = rd;
    v.writes = writes; v.widx = widx; v.word = word;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    int          lat, wr, anydone;
    logic        e;
    logic [31:0] r, a, wd, ref_rdata, exp_rd;
    logic [2:0]  f3;
    logic        we, legal;
    logic [7:0]  idx;

    //                 we  f3    addr          wdata          lat err rdata        wr idx    word
    vecs[0]  = mk(1'b0, 3'd0, 32'h41, 32'h0,          2, 1'b0, 32'hFFFF_FFAA, 0, 8'h10, 32'h8899_AABB);
    vecs[1]  = mk(1'b0, 3'd4, 32'h41, 32'h0,          2, 1'b0, 32'h0000_00AA, 0, 8'h10, 32'h8899_AABB);
    vecs[2]  = mk(1'b0, 3'd1, 32'h42, 32'h0,          2, 1'b0, 32'hFFFF_8899, 0, 8'h10, 32'h8899_AABB);
    vecs[3]  = mk(1'b0, 3'd5, 32'h42, 32'h0,          2, 1'b0, 32'h0000_8899, 0, 8'h10, 32'h8899_AABB);
    vecs[4]  = mk(1'b0, 3'd2, 32'h40, 32'h0,          2, 1'b0, 32'h8899_AABB, 0, 8'h10, 32'h8899_AABB);
    vecs[5]  = mk(1'b1, 3'd0, 32'h43, 32'h1234_5677,  3, 1'b0, 32'h8899_AABB, 1, 8'h10, 32'h7799_AABB);
    vecs[6]  = mk(1'b1, 3'd1, 32'h40, 32'hDEAD_BEEF,  3, 1'b0, 32'h8899_AABB, 1, 8'h10, 32'h7799_BEEF);
    vecs[7]  = mk(1'b0, 3'd2, 32'h40, 32'h0,          2, 1'b0, 32'h7799_BEEF, 0, 8'h10, 32'h7799_BEEF);
    vecs[8]  = mk(1'b1, 3'd2, 32'h44, 32'hCAFE_F00D,  2, 1'b0, 32'h7799_BEEF, 1, 8'h11, 32'hCAFE_F00D);
    vecs[9]  = mk(1'b0, 3'd2, 32'h44, 32'h0,          2, 1'b0, 32'hCAFE_F00D, 0, 8'h11, 32'hCAFE_F00D);
    vecs[10] = mk(1'b0, 3'd1, 32'h41, 32'h0,          1, 1'b1, 32'hCAFE_F00D, 0, 8'h10, 32'h7799_BEEF);
    vecs[11] = mk(1'b0, 3'd2, 32'h42, 32'h0,          1, 1'b1, 32'hCAFE_F00D, 0, 8'h10, 32'h7799_BEEF);
    vecs[12] = mk(1'b1, 3'd2, 32'h46, 32'h1111_1111,  1, 1'b1, 32'hCAFE_F00D, 0, 8'h11, 32'hCAFE_F00D);
    vecs[13] = mk(1'b0, 3'd3, 32'h40, 32'h0,          1, 1'b1, 32'hCAFE_F00D, 0, 8'h10, 32'h7799_BEEF);
    vecs[14] = mk(1'b1, 3'd4, 32'h44, 32'h2222_2222,  1, 1'b1, 32'hCAFE_F00D, 0, 8'h11, 32'hCAFE_F00D);

    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    poke(8'h10, 32'h8899_AABB);
    poke(8'h11, 32'h0000_0000);
    rst = 1'b0;
    @(posedge clk); #1;

    chk("reset_rdata", rdata, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_dm_write", {31'd0, dm_mem_write}, 32'd0);
    chk("reset_dm_address", dm_address, 32'h0);
    chk("reset_dm_wdata", dm_write_data, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, lat, e, wr);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].e});
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd);
      chk($sformatf("vec%0d_writes", i), 32'(wr), 32'(vecs[i].writes));
      chk($sformatf("vec%0d_memword", i), mem[vecs[i].widx], vecs[i].word);
      chk($sformatf("vec%0d_idle_after", i), {30'd0, busy, done}, 32'd0);
    end

    // Reset during the WRITE cycle of an SB must suppress the write and the done pulse
    poke(8'h12, 32'h1122_3344);
    mem_we = 1'b1; funct3 = 3'd0; addr = 32'h49; wdata = 32'hAB; mem_req = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    chk("rmw_busy_c1", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("rmw_write_c2", {31'd0, dm_mem_write}, 32'd1);
    chk("rmw_write_addr", dm_address, 32'h48);
    rst = 1'b1;
    #1;
    chk("rst_gates_write", {31'd0, dm_mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_low", {31'd0, busy}, 32'd0);
    anydone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) anydone++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", 32'(anydone), 32'd0);
    chk("rst_mem_kept", mem[8'h12], 32'h1122_3344);
    chk("rst_rdata_cleared", rdata, 32'h0);

    // mem_req while busy is ignored
    poke(8'h13, 32'h5555_5555);
    mem_we = 1'b1; funct3 = 3'd2; addr = 32'h48; wdata = 32'hA5A5_A5A5; mem_req = 1'b1;
    @(posedge clk); #1;
    addr = 32'h4C; wdata = 32'h0; mem_req = 1'b1;
    @(posedge clk); #1;
    chk("busy_req_done_c2", {31'd0, done}, 32'd1);
    mem_req = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("busy_req_sw_ok", mem[8'h12], 32'hA5A5_A5A5);
    chk("busy_req_ignored", mem[8'h13], 32'h5555_5555);

    // mem_req coinciding with reset is dropped
    mem_we = 1'b1; funct3 = 3'd2; addr = 32'h4C; wdata = 32'h0; mem_req = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0;
    chk("rst_req_busy", {31'd0, busy}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_req_mem", mem[8'h13], 32'h5555_5555);

    // Randomized traffic over 16 words against the model
    for (int i = 0; i < 16; i++) poke(8'(i), $urandom);
    ref_rdata = 32'h0;
    for (int n = 0; n < 200; n++) begin
      r  = $urandom;
      a  = {r[31:10], 4'b0000, r[5:0]};
      we = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      idx = 8'((a >> 2) & 255);
      legal = m_legal(we, f3, a);
      exp_rd = ref_rdata;
      if (legal && !we) exp_rd = m_load(ref_mem[idx], f3, a);
      if (legal && we) ref_mem[idx] = m_store(ref_mem[idx], wd, f3, a);
      ref_rdata = exp_rd;
      run_txn(we, f3, a, wd, lat, e, wr);
      chk($sformatf("rnd%0d_err", n), {31'd0, e}, {31'd0, !legal});
      chk($sformatf("rnd%0d_latency", n), 32'(lat),
          !legal ? 32'd1 : (we && f3 != 3'd2) ? 32'd3 : 32'd2);
      chk($sformatf("rnd%0d_writes", n), 32'(wr), (legal && we) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_rdata", n), rdata, exp_rd);
      chk($sformatf("rnd%0d_mem", n), mem[idx], ref_mem[idx]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the core's execute stage and the word-addressed data memory. Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses. Sub-word stores use a read-modify-write sequence, and sub-word loads are extracted and sign- or zero-extended. Misaligned or illegal requests are rejected, and no memory access is made for them.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- mem_req  in  1  request strobe; sampled only in IDLE
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code
- addr  in  32  byte address
- wdata  in  32  store data; low byte/half used for SB/SH
- rdata  out  32  extended load result; registered
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on a rejected request
- busy  out  1  high whenever state ≠ IDLE
- dm_address  out  32  word-aligned address to data memory
- dm_write_data  out  32  word to write
- dm_mem_write  out  1  data memory write enable
- dm_read_data  in  32  data memory combinational read word

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- In IDLE with mem_req=1, latch addr, wdata, funct3 and mem_we, then check legality:
  - Loads: legal funct3 ∈ {0,1,2,4,5}.
  - Stores: legal funct3 ∈ {0,1,2}.
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
- Illegal request: IDLE→RESP with err=1. No write occurs, and rdata is unchanged.
- Load: IDLE→LOAD→RESP.
  - In LOAD, select the byte/half lane from dm_read_data using addr[1:0] (little-endian).
  - Extend per funct3 (0,1 sign; 4,5 zero; 2 word) and register the result into rdata.
- SW: IDLE→WRITE→RESP. In WRITE, dm_write_data = wdata.
- SB/SH: IDLE→RMW_RD→WRITE→RESP.
  - RMW_RD captures dm_read_data.
  - WRITE writes the captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Other lanes are preserved bit-exact.
- RESP: done=1 for one cycle, then →IDLE.
- mem_req is ignored while busy; there is no queuing.
- rdata holds its value until the next successful load.
- dm_address = {latched addr[31:2], 2'b00} while busy, else 0.
- dm_mem_write = (state==WRITE) && !rst. Because of the !rst term, an asserted reset suppresses an in-flight write in the same cycle.

## Timing
- Reset values: state=IDLE, rdata=0, done=0, err=0, busy=0, dm_mem_write=0, dm_address=0, dm_write_data=0.
- Latency from the accepting edge (cycle 0) to the done pulse:
  - load, SW, and illegal requests: done in cycle 2 (illegal: cycle 1);
  - SB/SH: done in cycle 3.
- A new request is accepted in the cycle after RESP at the earliest. Throughput is one access per 3 cycles (loads, SW) or 4 cycles (SB/SH).
- The memory write commits at the clk edge ending WRITE. A load issued next sees the new data.
- Reset mid-operation returns to IDLE on the next edge. A partial RMW never writes, and no done pulse is produced.
- A mem_req coinciding with rst is dropped.
- addr at the top of the address space is not special-cased. Only bits [31:2] reach memory.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - state enum;
  - a legality function is_legal(we, funct3, addr[1:0]).
- Sub-module lsu_align, purely combinational, contains:
  - load extract/extend: (word, off, funct3) → rdata;
  - store merge: (old, wdata, off, funct3) → new word.
- The FSM stays in lsu_ctrl.

## Test plan
- After reset, memory word 0x40 = 0x8899AABB. LB addr 0x41 → rdata=0xFFFFFFAA and done in cycle 2. LBU 0x41 → 0x000000AA.
- Same word, LH addr 0x42 → 0xFFFF8899. LHU 0x42 → 0x00008899. LW 0x40 → 0x8899AABB.
- SB addr 0x43, wdata=0x12345677. Memory at 0x40 becomes 0x7799AABB, dm_mem_write high for exactly 1 cycle, and done in cycle 3.
- SH addr 0x40, wdata=0xDEADBEEF, then LW 0x40 → 0x7799BEEF. SW 0x44 = 0xCAFEF00D, then LW → 0xCAFEF00D.
- LH at 0x41, LW at 0x42, SW at 0x46, and load funct3=3 each → err=done=1 in cycle 1, no dm_mem_write, rdata unchanged.
- SB in flight with rst asserted during WRITE → memory unchanged, done never pulses, busy=0 after the edge. mem_req pulses during busy are ignored (memory contents checked).
